// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot receiver/transmitter state encodings and
// default frame geometry.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef logic [3:0] state_t;

    localparam state_t IDLE  = 4'b0001;
    localparam state_t START = 4'b0010;
    localparam state_t DATA  = 4'b0100;
    localparam state_t STOP  = 4'b1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_count,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick enable; presents each
// correctly framed byte on d_out with a one-clk rx_done strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_count,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CNT_W-1:0]     tick_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic start_edge;
    logic mid_hit;
    logic full_hit;
    logic cnt_clr;
    logic cnt_en;
    logic idx_clr;
    logic shift_en;
    logic load_en;
    logic err_en;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk       (clk),
        .rst_count (rst_count),
        .d         (rx),
        .q         (rx_s)
    );

    assign cnt_inc    = tick_cnt + CNT_W'(1);
    assign start_edge = rx_prev & ~rx_s;
    assign mid_hit    = baud_tick && (cnt_inc == CNT_MID);
    // Counter wraps to zero on this tick, marking one full bit period.
    assign full_hit   = baud_tick && (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            state   <= IDLE;
            rx_prev <= 1'b1;
        end else begin
            state   <= state_nxt;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = START;
            START:   if (mid_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (full_hit && (bit_idx == IDX_LAST)) state_nxt = STOP;
            STOP:    if (full_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        err_en   = 1'b0;
        case (state)
            IDLE: cnt_clr = 1'b1;
            START: begin
                cnt_en = baud_tick;
                if (mid_hit && !rx_s) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            DATA: begin
                cnt_en   = baud_tick;
                shift_en = full_hit;
            end
            STOP: begin
                cnt_en  = baud_tick;
                load_en = full_hit & rx_s;
                err_en  = full_hit & ~rx_s;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (cnt_clr)
                tick_cnt <= '0;
            else if (cnt_en)
                tick_cnt <= cnt_inc;
            if (idx_clr)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + IDX_W'(1);
            if (load_en)
                d_out <= shift_reg;
            rx_done   <= load_en;
            frame_err <= err_en;
        end
    end

    // Shift register is pure datapath; d_out only ever sees it after a full frame.
    always_ff @(posedge clk) begin
        if (shift_en)
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// back-to-back, false-start, break and mid-frame reset sequences.
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;
    localparam int T_MIN    = 607;
    localparam int T_MAX    = 612;

    logic       clk = 1'b0;
    logic       rst_count;
    logic       baud_tick = 1'b0;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    int cyc = 0;
    int div = 0;
    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int last_evt_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] cap_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_d;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    uart_rx dut (
        .clk       (clk),
        .rst_count (rst_count),
        .baud_tick (baud_tick),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        div <= (div == TICK_DIV - 1) ? 0 : div + 1;
        baud_tick <= (div == TICK_DIV - 1);
    end

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            cap_q.push_back(d_out);
            last_evt_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            last_evt_cyc = cyc;
        end
        if (rx_done && frame_err) both_cnt++;
        if ((rx_done && prev_done) || (frame_err && prev_err)) wide_cnt++;
        prev_done = rx_done;
        prev_err  = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int start_c);
        @(posedge clk);
        #1;
        start_c = cyc;
        drive_bit(1'b0);
        for (int b = 0; b < 8; b++) drive_bit(data[b]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #1;
    endtask

    initial begin
        int sc;
        int d0;
        int e0;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'h55, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[5] = '{8'h01, 1'b0, 8'h80, 0, 1};
        vecs[6] = '{8'hC5, 1'b1, 8'hC5, 1, 0};

        rst_count = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", d_out, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst_count = 1'b1;
        idle_bits(1);
        check("post_rst_pulses", done_cnt + err_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit, sc);
            idle_bits(2);
            check($sformatf("v%0d_dout", i), d_out, vecs[i].exp_d);
            check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d_ferr", i), err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].exp_done + vecs[i].exp_err > 0)
                check_range($sformatf("v%0d_timing", i), last_evt_cyc - sc, T_MIN, T_MAX);
        end

        // Back-to-back frames, no idle gap between stop and next start.
        cap_q.delete();
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1, sc);
        send_frame(8'h0F, 1'b1, sc);
        idle_bits(2);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_first", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, 8'hA3);
        check("b2b_second", (cap_q.size() > 1) ? cap_q[1] : 8'hxx, 8'h0F);
        check("b2b_dout", d_out, 8'h0F);

        // False start: low for 3 ticks only.
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(posedge clk);
        #1;
        idle_bits(3);
        check("fs_done", done_cnt - d0, 0);
        check("fs_ferr", err_cnt - e0, 0);
        check("fs_dout", d_out, 8'h0F);
        send_frame(8'h6A, 1'b1, sc);
        idle_bits(1);
        check("fs_recover", d_out, 8'h6A);
        check_range("fs_recover_timing", last_evt_cyc - sc, T_MIN, T_MAX);

        // Break: 40 bit times low, then a normal frame.
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (40 * BIT_CLKS) @(posedge clk);
        #1;
        idle_bits(2);
        check("brk_ferr", err_cnt - e0, 1);
        check("brk_done", done_cnt - d0, 0);
        check("brk_dout", d_out, 8'h6A);
        send_frame(8'h81, 1'b1, sc);
        idle_bits(1);
        check("brk_next_dout", d_out, 8'h81);
        check("brk_next_done", done_cnt - d0, 1);
        check("brk_next_ferr", err_cnt - e0, 1);

        // Reset asserted at tick 70 of frame 0xFF.
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            send_frame(8'hFF, 1'b1, sc);
            begin
                @(posedge clk);
                repeat (70 * TICK_DIV) @(posedge clk);
                #1;
                rst_count = 1'b0;
                #1;
                check("mrst_dout", d_out, 8'h00);
                check("mrst_done", rx_done, 1'b0);
                check("mrst_ferr", frame_err, 1'b0);
                repeat (3) @(posedge clk);
                #1;
                rst_count = 1'b1;
            end
        join
        idle_bits(2);
        check("mrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        check("mrst_dout_after", d_out, 8'h00);
        send_frame(8'h12, 1'b1, sc);
        idle_bits(1);
        check("mrst_next_dout", d_out, 8'h12);
        check("mrst_next_done", done_cnt - d0, 1);
        check_range("mrst_next_timing", last_evt_cyc - sc, T_MIN, T_MAX);

        check("never_both", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link. It recovers 8N1 frames from the asynchronous `rx` line using the shared 16x-oversampled `baud_tick` enable. Each good byte is presented on `d_out` with a one-cycle `rx_done` strobe. It is the receive-side counterpart of the transmitter and feeds the byte-level consumers (command decoder / FIFO) downstream.

## Interface
- `DATA_BITS`, 8, payload bits per frame, LSB first.
- `OVERSAMPLE`, 16, baud_tick pulses per bit period; must be even and a power of two.

Ports, clock and reset first:
- `clk`  in  1  system clock.
- `rst_count`  in  1  reset, asynchronous, active-low; clock `clk`.
- `baud_tick`  in  1  one-`clk`-wide enable at `OVERSAMPLE` x baud, synchronous to `clk`.
- `rx`  in  1  asynchronous serial input; idle high.
- `d_out`  out  `DATA_BITS`  last correctly framed byte; holds until the next good frame.
- `rx_done`  out  1  one-`clk` pulse when `d_out` is updated.
- `frame_err`  out  1  one-`clk` pulse when the stop bit samples low.

## Operation
- `rx` passes through a 2-flop synchronizer, which resets to 1. An edge register holds the previous synchronized value, which also resets to 1.
- State machine is one-hot, with states IDLE, START, DATA, STOP.
- **IDLE**
  - Tick counter is held at 0.
  - A start is detected only on a synchronized 1→0 transition. The transition is qualified per `clk`, not per tick. On detection, go to START.
  - A line held low (break) never re-triggers until it has returned high.
- **START**
  - Count `baud_tick`.
  - On the tick that brings the count to `OVERSAMPLE/2` (the 8th tick), sample the line:
    - If 0: clear the counter, clear the bit index, go to DATA.
    - If 1 (glitch or false start): go to IDLE with no output activity.
- **DATA**
  - On every `OVERSAMPLE`-th tick, sample the line and shift it in at the MSB of the shift register (right shift), so the first bit received lands in bit 0. Increment the bit index.
  - After bit index `DATA_BITS-1` is sampled, go to STOP.
- **STOP**
  - On the `OVERSAMPLE`-th tick, sample the line:
    - If 1: load the shift register into `d_out` and pulse `rx_done`.
    - If 0: pulse `frame_err`; `d_out` is unchanged.
  - Either way, go to IDLE. Returning at mid-stop-bit allows back-to-back frames.
- Tick counter is 4 bits (log2 `OVERSAMPLE`) and wraps naturally. It only counts in START, DATA and STOP. Bit index is 3 bits.
- `rx_done` and `frame_err` are never both high.
- A `baud_tick` coinciding with the IDLE→START transition is not counted.

## Timing
- Reset values: `d_out`=0, `rx_done`=0, `frame_err`=0, state IDLE, counters 0.
- Assertion of `rst_count` mid-frame aborts immediately, with no pulse and `d_out` cleared. After release, the receiver waits for a fresh 1→0 edge.
- Sample points, measured in ticks after start detection:
  - start bit at tick 8;
  - data bit k (k=0..7) at tick 24+16k;
  - stop bit at tick 152.
- `rx_done` / `frame_err` rise on the `clk` edge that registers the tick-152 sample. They are high for exactly one `clk`.
- Input latency is 2 `clk` (synchronizer) plus 1 `clk` (edge detect) before START.
- No handshake: the consumer must capture `d_out` on `rx_done`. `d_out` stays stable for at least one frame time.

## Structure
- Package `uart_pkg` holds:
  - one-hot state localparams (IDLE=4'b0001, START=4'b0010, DATA=4'b0100, STOP=4'b1000);
  - `OVERSAMPLE` and `DATA_BITS` defaults.
  - The transmitter shares this package.
- Sub-module `sync_2ff` provides the `rx` double-flop synchronizer with reset value 1. It is reusable for other async inputs.

## Test plan
- **Single frame:** frame 0x55 at 16 ticks/bit, tick every 4 `clk` → `d_out`=0x55, one `rx_done` pulse at tick 152, `frame_err`=0.
- **Back-to-back frames:** 0xA3 then 0x0F with no idle gap → two `rx_done` pulses, `d_out`=0xA3 then 0x0F.
- **False start:** `rx` low for 3 ticks then high → no `rx_done` or `frame_err`; FSM returns to IDLE by tick 8.
- **Framing error:** frame 0x3C with stop bit driven 0 → `frame_err` pulse at tick 152, `d_out` keeps its previous value, no `rx_done`.
- **Break:** `rx` held low for 40 bit times, then released high, then frame 0x81 sent → exactly one `frame_err`, then `d_out`=0x81 with `rx_done`.
- **Reset mid-frame:** `rst_count` pulsed low at tick 70 of frame 0xFF → all outputs 0, no pulse; the next full frame 0x12 is received correctly.
